// File: rtl/reg_bus_initiator.sv
// Register bus initiator: queues write/read commands and sequences each one as a
// three-phase access (setup, strobe, recover), returning checked read data.
module reg_bus_initiator #(
    parameter int unsigned ADDRWIDTH  = 4,
    parameter int unsigned DATAWIDTH  = 8,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter logic [ADDRWIDTH-1:0] IDLE_ADDR = {ADDRWIDTH{1'b1}}
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic                 cmd_write,
    input  logic [ADDRWIDTH-1:0] cmd_addr,
    input  logic [DATAWIDTH-1:0] cmd_wdata,
    input  logic                 cmd_check,
    output logic [ADDRWIDTH-1:0] addr,
    output logic                 wen,
    output logic [DATAWIDTH-1:0] wr_data,
    output logic                 ren,
    input  logic [DATAWIDTH-1:0] rd_data,
    output logic                 rsp_valid,
    output logic [DATAWIDTH-1:0] rsp_data,
    output logic                 rsp_match,
    output logic [7:0]           mismatch_cnt,
    output logic                 busy
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef struct packed {
        logic                 write;
        logic [ADDRWIDTH-1:0] addr;
        logic [DATAWIDTH-1:0] wdata;
        logic                 check;
    } cmd_t;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SETUP   = 3'd1,
        STROBE  = 3'd2,
        RECOVER = 3'd3,
        CAPTURE = 3'd4
    } state_t;

    cmd_t             fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_nxt;
    logic             full;
    logic             empty;
    logic             push_c;
    logic             pop_c;

    state_t state;
    state_t state_nxt;
    cmd_t   act;
    cmd_t   cmd_nxt;
    logic   rd_mismatch_c;

    assign full      = (count == CNT_W'(FIFO_DEPTH));
    assign empty     = (count == '0);
    assign cmd_ready = !full;
    assign push_c    = cmd_valid && !full;

    always_comb begin
        count_nxt = count;
        case ({push_c, pop_c})
            2'b10:   count_nxt = count + CNT_W'(1);
            2'b01:   count_nxt = count - CNT_W'(1);
            default: count_nxt = count;
        endcase
    end

    // Queue storage carries no reset; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (push_c) begin
            fifo_mem[wr_ptr] <= '{write: cmd_write, addr: cmd_addr,
                                  wdata: cmd_wdata, check: cmd_check};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_c) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop_c)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count_nxt;
        end
    end

    // Next state; a pop loads the queue head as the command for the coming SETUP.
    always_comb begin
        state_nxt = state;
        pop_c     = 1'b0;
        cmd_nxt   = act;
        case (state)
            IDLE: begin
                if (!empty) begin
                    state_nxt = SETUP;
                    pop_c     = 1'b1;
                end
            end
            SETUP:  state_nxt = STROBE;
            STROBE: state_nxt = RECOVER;
            RECOVER: begin
                if (!act.write) begin
                    state_nxt = CAPTURE;
                end else if (!empty) begin
                    state_nxt = SETUP;
                    pop_c     = 1'b1;
                end else begin
                    state_nxt = IDLE;
                end
            end
            CAPTURE: begin
                if (!empty) begin
                    state_nxt = SETUP;
                    pop_c     = 1'b1;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (pop_c) cmd_nxt = fifo_mem[rd_ptr];
    end

    assign rd_mismatch_c = (rd_data != act.wdata);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Bus and response registers are loaded from the state being entered.
    always_ff @(posedge clk) begin
        if (rst) begin
            act          <= '0;
            addr         <= IDLE_ADDR;
            wen          <= 1'b0;
            ren          <= 1'b0;
            wr_data      <= '0;
            rsp_valid    <= 1'b0;
            rsp_data     <= '0;
            rsp_match    <= 1'b0;
            mismatch_cnt <= 8'h00;
            busy         <= 1'b0;
        end else begin
            act     <= cmd_nxt;
            addr    <= IDLE_ADDR;
            wen     <= 1'b0;
            ren     <= 1'b0;
            wr_data <= '0;
            case (state_nxt)
                SETUP: addr <= cmd_nxt.addr;
                STROBE: begin
                    addr <= cmd_nxt.addr;
                    wen  <= cmd_nxt.write;
                    ren  <= !cmd_nxt.write;
                    if (cmd_nxt.write) wr_data <= cmd_nxt.wdata;
                end
                default: ;
            endcase

            rsp_valid <= 1'b0;
            if (state == RECOVER && !act.write) begin
                rsp_valid <= 1'b1;
                rsp_data  <= rd_data;
                rsp_match <= !act.check || !rd_mismatch_c;
                if (act.check && rd_mismatch_c && mismatch_cnt != 8'hff) begin
                    mismatch_cnt <= mismatch_cnt + 8'd1;
                end
            end

            busy <= (state_nxt != IDLE) || (count_nxt != '0);
        end
    end

endmodule

// File: tb/tb_reg_bus_initiator.sv
// Directed bench for reg_bus_initiator with a small registered register-file responder.
module tb_reg_bus_initiator;

    logic       clk_tb = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic       cmd_write = 1'b0;
    logic [3:0] cmd_addr = 4'h0;
    logic [7:0] cmd_wdata = 8'h00;
    logic       cmd_check = 1'b0;
    logic [3:0] addr;
    logic       wen;
    logic [7:0] wr_data;
    logic       ren;
    logic [7:0] rd_data = 8'h00;
    logic       rsp_valid;
    logic [7:0] rsp_data;
    logic       rsp_match;
    logic [7:0] mismatch_cnt;
    logic       busy;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int both_hi = 0;

    typedef struct {
        logic [7:0] data;
        logic       match;
        logic [7:0] cnt;
        int         cyc;
    } rsp_t;

    rsp_t        rsp_q[$];
    logic [11:0] wr_log[$];
    logic [7:0]  regs[16];

    reg_bus_initiator dut (
        .clk(clk_tb), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_check(cmd_check),
        .addr(addr), .wen(wen), .wr_data(wr_data), .ren(ren), .rd_data(rd_data),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_match(rsp_match),
        .mismatch_cnt(mismatch_cnt), .busy(busy)
    );

    always #5 clk_tb = ~clk_tb;

    always @(posedge clk_tb) cyc <= cyc + 1;

    // Register-file responder: read data is registered off the read strobe.
    always @(posedge clk_tb) begin
        if (wen) regs[addr] <= wr_data;
        if (ren) rd_data <= regs[addr];
    end

    always @(negedge clk_tb) begin
        if (rsp_valid) rsp_q.push_back('{rsp_data, rsp_match, mismatch_cnt, cyc});
        if (wen) wr_log.push_back({addr, wr_data});
        if (wen && ren) both_hi++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_tb);
        #1;
    endtask

    // Offer one command and return 1 time unit after the edge that accepts it.
    task automatic push(input logic w, input logic [3:0] a, input logic [7:0] d, input logic c);
        int n = 0;
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = a;
        cmd_wdata = d;
        cmd_check = c;
        while (!cmd_ready && n < 50) begin
            step();
            n++;
        end
        chk("push_ready", 32'(cmd_ready), 32'd1);
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 300) begin
            step();
            n++;
        end
        chk("wait_idle", 32'(busy), 32'd0);
    endtask

    initial begin
        int t0;
        rsp_t r;
        for (int i = 0; i < 16; i++) regs[i] = 8'h00;

        // Reset values
        repeat (2) step();
        chk("rst_addr", 32'(addr), 32'hf);
        chk("rst_wen", 32'(wen), 32'd0);
        chk("rst_ren", 32'(ren), 32'd0);
        chk("rst_wr_data", 32'(wr_data), 32'h00);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_data", 32'(rsp_data), 32'h00);
        chk("rst_rsp_match", 32'(rsp_match), 32'd0);
        chk("rst_mcnt", 32'(mismatch_cnt), 32'h00);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        rst = 1'b0;
        step();

        // Write timing
        push(1'b1, 4'h0, 8'ha5, 1'b0);
        chk("w_n_addr", 32'(addr), 32'hf);
        chk("w_n_busy", 32'(busy), 32'd1);
        step();
        chk("w_setup_addr", 32'(addr), 32'h0);
        chk("w_setup_wen", 32'(wen), 32'd0);
        chk("w_setup_wr_data", 32'(wr_data), 32'h00);
        step();
        chk("w_strobe_addr", 32'(addr), 32'h0);
        chk("w_strobe_wen", 32'(wen), 32'd1);
        chk("w_strobe_wr_data", 32'(wr_data), 32'ha5);
        chk("w_strobe_ren", 32'(ren), 32'd0);
        step();
        chk("w_rec_addr", 32'(addr), 32'hf);
        chk("w_rec_wen", 32'(wen), 32'd0);
        chk("w_rec_wr_data", 32'(wr_data), 32'h00);
        chk("w_rec_busy", 32'(busy), 32'd1);
        step();
        chk("w_done_busy", 32'(busy), 32'd0);

        // Checked read that matches
        push(1'b0, 4'h0, 8'ha5, 1'b1);
        step();
        chk("r_setup_addr", 32'(addr), 32'h0);
        chk("r_setup_ren", 32'(ren), 32'd0);
        step();
        chk("r_strobe_ren", 32'(ren), 32'd1);
        chk("r_strobe_wen", 32'(wen), 32'd0);
        chk("r_strobe_addr", 32'(addr), 32'h0);
        step();
        chk("r_rec_ren", 32'(ren), 32'd0);
        chk("r_rec_addr", 32'(addr), 32'hf);
        chk("r_rec_rsp_valid", 32'(rsp_valid), 32'd0);
        step();
        chk("r_cap_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("r_cap_rsp_data", 32'(rsp_data), 32'ha5);
        chk("r_cap_rsp_match", 32'(rsp_match), 32'd1);
        chk("r_cap_mcnt", 32'(mismatch_cnt), 32'h00);
        step();
        chk("r_after_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("r_after_busy", 32'(busy), 32'd0);

        // Sequence on regs 0-3, 4 writes + 4 reads back to back
        rsp_q.delete();
        wr_log.delete();
        push(1'b1, 4'h0, 8'ha5, 1'b0);
        t0 = cyc;
        push(1'b0, 4'h0, 8'ha5, 1'b1);
        push(1'b1, 4'h1, 8'ha6, 1'b0);
        push(1'b0, 4'h1, 8'ha6, 1'b1);
        push(1'b1, 4'h2, 8'ha7, 1'b0);
        push(1'b0, 4'h2, 8'ha7, 1'b1);
        push(1'b1, 4'h3, 8'ha8, 1'b0);
        push(1'b0, 4'h3, 8'ha8, 1'b1);
        wait_idle();
        chk("seq_rsp_count", 32'(rsp_q.size()), 32'd4);
        chk("seq_wr_count", 32'(wr_log.size()), 32'd4);
        for (int i = 0; i < 4 && i < rsp_q.size(); i++) begin
            chk("seq_rsp_data", 32'(rsp_q[i].data), 32'(8'ha5 + 8'(i)));
            chk("seq_rsp_match", 32'(rsp_q[i].match), 32'd1);
        end
        if (rsp_q.size() == 4) chk("seq_last_rsp_cycle", 32'(rsp_q[3].cyc - t0), 32'd28);
        chk("seq_mcnt", 32'(mismatch_cnt), 32'h00);

        // FIFO full: six writes offered with cmd_valid held
        wr_log.delete();
        for (int i = 0; i < 6; i++) push(1'b1, 4'(4 + i), 8'(8'h30 + i), 1'b0);
        chk("full_cmd_ready", 32'(cmd_ready), 32'd0);
        chk("full_busy", 32'(busy), 32'd1);
        wait_idle();
        chk("full_wr_count", 32'(wr_log.size()), 32'd6);
        for (int i = 0; i < 6 && i < wr_log.size(); i++) begin
            chk("full_wr_order", 32'(wr_log[i]), 32'({4'(4 + i), 8'(8'h30 + i)}));
        end
        chk("full_ready_after", 32'(cmd_ready), 32'd1);

        // Mismatch counter saturation: 257 checked reads of a5 expecting 00
        rsp_q.delete();
        for (int i = 0; i < 257; i++) push(1'b0, 4'h0, 8'h00, 1'b1);
        wait_idle();
        chk("mm_rsp_count", 32'(rsp_q.size()), 32'd257);
        for (int i = 0; i < rsp_q.size(); i++) begin
            r = rsp_q[i];
            chk("mm_rsp_match", 32'(r.match), 32'd0);
            chk("mm_cnt", 32'(r.cnt), (i < 254) ? 32'(i + 1) : 32'hff);
        end
        chk("mm_cnt_final", 32'(mismatch_cnt), 32'hff);

        // Reset during STROBE of a read, with two writes still queued
        rsp_q.delete();
        wr_log.delete();
        push(1'b0, 4'h0, 8'ha5, 1'b1);
        push(1'b1, 4'h5, 8'h11, 1'b0);
        chk("rr_setup_addr", 32'(addr), 32'h0);
        push(1'b1, 4'h6, 8'h22, 1'b0);
        chk("rr_strobe_ren", 32'(ren), 32'd1);
        rst = 1'b1;
        step();
        chk("rr_ren", 32'(ren), 32'd0);
        chk("rr_addr", 32'(addr), 32'hf);
        chk("rr_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rr_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rr_mcnt", 32'(mismatch_cnt), 32'h00);
        chk("rr_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        repeat (8) step();
        chk("rr_no_rsp", 32'(rsp_q.size()), 32'd0);
        chk("rr_no_write", 32'(wr_log.size()), 32'd0);
        chk("rr_idle_busy", 32'(busy), 32'd0);

        chk("strobe_exclusive", 32'(both_hi), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
